// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flushes and multi-cycle multiply freezes.
// Optional stalled-cycle counter is built only when HAZARD_CTRL_PERF_EN is defined.
module hazard_ctrl #(
  parameter int MUL_LAT = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [4:0]  rsaddr_i,
  input  logic [4:0]  rtaddr_i,
  input  logic        ex_memread_i,
  input  logic [4:0]  ex_rtaddr_i,
  input  logic        branch_taken_i,
  input  logic        mul_issue_i,
  output logic        pc_write_o,
  output logic        ifid_write_o,
  output logic        ifid_flush_o,
  output logic        bubble_o,
  output logic        mul_busy_o,
  output logic [31:0] stall_cnt_o
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    MUL_WAIT = 2'd2
  } state_t;

  localparam logic [3:0] MCNT_LOAD = 4'(MUL_LAT - 1);

  state_t     state_r;
  logic [3:0] mcnt_r;
  logic       mul_busy_r;
  logic       lu_s;
  logic       pc_write_s;
  logic       ifid_write_s;
  logic       ifid_flush_s;
  logic       bubble_s;

  // r0 is hardwired zero, so a load targeting it never creates a dependency
  function automatic logic load_use(input logic       memread,
                                    input logic [4:0] ex_rt,
                                    input logic [4:0] rs,
                                    input logic [4:0] rt);
    return memread & (ex_rt != 5'd0) & ((ex_rt == rs) | (ex_rt == rt));
  endfunction

  assign lu_s = (state_r == RUN) && load_use(ex_memread_i, ex_rtaddr_i, rsaddr_i, rtaddr_i);

  // Front-end control decode: the load-use stall must act in the same cycle
  always_comb begin
    pc_write_s   = 1'b0;
    ifid_write_s = 1'b0;
    ifid_flush_s = 1'b0;
    bubble_s     = 1'b1;
    case (state_r)
      IDLE: begin
        pc_write_s   = 1'b0;
        ifid_write_s = 1'b0;
        bubble_s     = 1'b1;
      end
      RUN: begin
        if (lu_s) begin
          pc_write_s   = 1'b0;
          ifid_write_s = 1'b0;
          bubble_s     = 1'b1;
        end else begin
          pc_write_s   = 1'b1;
          ifid_write_s = 1'b1;
          bubble_s     = 1'b0;
          // a multiply in the same cycle outranks the branch
          ifid_flush_s = branch_taken_i & ~mul_issue_i;
        end
      end
      MUL_WAIT: begin
        pc_write_s   = 1'b0;
        ifid_write_s = 1'b0;
        bubble_s     = 1'b1;
      end
      default: begin
        pc_write_s   = 1'b0;
        ifid_write_s = 1'b0;
        bubble_s     = 1'b1;
      end
    endcase
  end

  // State sequencing, multiply countdown and registered busy flag
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r    <= IDLE;
      mcnt_r     <= 4'd0;
      mul_busy_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start_i) begin
            state_r <= RUN;
          end else begin
            state_r <= IDLE;
          end
          mcnt_r     <= 4'd0;
          mul_busy_r <= 1'b0;
        end
        RUN: begin
          if (!lu_s && mul_issue_i) begin
            state_r    <= MUL_WAIT;
            mcnt_r     <= MCNT_LOAD;
            mul_busy_r <= 1'b1;
          end else begin
            state_r    <= RUN;
            mcnt_r     <= 4'd0;
            mul_busy_r <= 1'b0;
          end
        end
        MUL_WAIT: begin
          // <= also recovers from a corrupted zero count
          if (mcnt_r <= 4'd1) begin
            state_r    <= RUN;
            mcnt_r     <= 4'd0;
            mul_busy_r <= 1'b0;
          end else begin
            state_r    <= MUL_WAIT;
            mcnt_r     <= mcnt_r - 4'd1;
            mul_busy_r <= 1'b1;
          end
        end
        default: begin
          state_r    <= IDLE;
          mcnt_r     <= 4'd0;
          mul_busy_r <= 1'b0;
        end
      endcase
    end
  end

`ifdef HAZARD_CTRL_PERF_EN
  logic [31:0] stall_cnt_r;

  // Saturating count of frozen front-end cycles while the pipeline is active
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_r <= 32'd0;
    end else if ((state_r == RUN || state_r == MUL_WAIT) && !pc_write_s &&
                 (stall_cnt_r != 32'hFFFF_FFFF)) begin
      stall_cnt_r <= stall_cnt_r + 32'd1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall_cnt_o = stall_cnt_r;
`else
  assign stall_cnt_o = 32'd0;
`endif

  assign pc_write_o   = pc_write_s;
  assign ifid_write_o = ifid_write_s;
  assign ifid_flush_o = ifid_flush_s;
  assign bubble_o     = bubble_s;
  assign mul_busy_o   = mul_busy_r;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (MUL_LAT = 4).
module tb_hazard_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [4:0]  rsaddr_i;
  logic [4:0]  rtaddr_i;
  logic        ex_memread_i;
  logic [4:0]  ex_rtaddr_i;
  logic        branch_taken_i;
  logic        mul_issue_i;
  logic        pc_write_o;
  logic        ifid_write_o;
  logic        ifid_flush_o;
  logic        bubble_o;
  logic        mul_busy_o;
  logic [31:0] stall_cnt_o;

  int checks = 0;
  int errors = 0;
  int exp_stalls = 0;

`ifdef HAZARD_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // {pc_write, ifid_write, ifid_flush, bubble, mul_busy}
  localparam logic [4:0] IDLE_V = 5'b00010;
  localparam logic [4:0] NORM_V = 5'b11000;
  localparam logic [4:0] STALL_V = 5'b00010;
  localparam logic [4:0] FLUSH_V = 5'b11100;
  localparam logic [4:0] MWAIT_V = 5'b00011;

  logic [4:0]  obs;
  logic [31:0] exp_cnt;
  assign obs = {pc_write_o, ifid_write_o, ifid_flush_o, bubble_o, mul_busy_o};
  assign exp_cnt = PERF ? 32'(exp_stalls) : 32'd0;

  hazard_ctrl #(.MUL_LAT(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .rsaddr_i(rsaddr_i), .rtaddr_i(rtaddr_i),
    .ex_memread_i(ex_memread_i), .ex_rtaddr_i(ex_rtaddr_i),
    .branch_taken_i(branch_taken_i), .mul_issue_i(mul_issue_i),
    .pc_write_o(pc_write_o), .ifid_write_o(ifid_write_o),
    .ifid_flush_o(ifid_flush_o), .bubble_o(bubble_o),
    .mul_busy_o(mul_busy_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic cyc();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic clear_inputs();
    start_i = 1'b0; rsaddr_i = 5'd0; rtaddr_i = 5'd0;
    ex_memread_i = 1'b0; ex_rtaddr_i = 5'd0;
    branch_taken_i = 1'b0; mul_issue_i = 1'b0;
  endtask

  task automatic reset_and_start();
    @(negedge clk_i);
    clear_inputs();
    rst_i = 1'b0;
    #1;
    rst_i = 1'b1;
    exp_stalls = 0;
    start_i = 1'b1;
    cyc();
    start_i = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_i = 1'b0;
    #2;
    checks++; if (obs !== IDLE_V) begin errors++; $display("FAIL reset_ctrl: got %b exp %b", obs, IDLE_V); end
    checks++; if (stall_cnt_o !== 32'd0) begin errors++; $display("FAIL reset_cnt: got %0d exp 0", stall_cnt_o); end
    @(negedge clk_i);
    rst_i = 1'b1;
    cyc();
    #1;
    checks++; if (obs !== IDLE_V) begin errors++; $display("FAIL idle_no_start: got %b exp %b", obs, IDLE_V); end
    start_i = 1'b1;
    #1;
    checks++; if (obs !== IDLE_V) begin errors++; $display("FAIL idle_before_edge: got %b exp %b", obs, IDLE_V); end
    cyc();
    start_i = 1'b0;
    #1;
    checks++; if (obs !== NORM_V) begin errors++; $display("FAIL run_after_start: got %b exp %b", obs, NORM_V); end
  endtask

  task automatic test_load_use();
    ex_memread_i = 1'b1; ex_rtaddr_i = 5'd5; rtaddr_i = 5'd5; rsaddr_i = 5'd0;
    #1;
    checks++; if (obs !== STALL_V) begin errors++; $display("FAIL lu_rt: got %b exp %b", obs, STALL_V); end
    exp_stalls++;
    cyc();
    ex_memread_i = 1'b0;
    #1;
    checks++; if (obs !== NORM_V) begin errors++; $display("FAIL lu_one_cycle: got %b exp %b", obs, NORM_V); end
    cyc();
    ex_memread_i = 1'b1; ex_rtaddr_i = 5'd7; rsaddr_i = 5'd7; rtaddr_i = 5'd3;
    #1;
    checks++; if (obs !== STALL_V) begin errors++; $display("FAIL lu_rs: got %b exp %b", obs, STALL_V); end
    exp_stalls++;
    cyc();
    ex_rtaddr_i = 5'd0; rsaddr_i = 5'd0; rtaddr_i = 5'd0;
    #1;
    checks++; if (obs !== NORM_V) begin errors++; $display("FAIL lu_r0: got %b exp %b", obs, NORM_V); end
    cyc();
    ex_rtaddr_i = 5'd9; rsaddr_i = 5'd8; rtaddr_i = 5'd10;
    #1;
    checks++; if (obs !== NORM_V) begin errors++; $display("FAIL lu_nomatch: got %b exp %b", obs, NORM_V); end
    cyc();
    ex_memread_i = 1'b0; rsaddr_i = 5'd9;
    #1;
    checks++; if (obs !== NORM_V) begin errors++; $display("FAIL lu_not_load: got %b exp %b", obs, NORM_V); end
    cyc();
    clear_inputs();
    #1;
    checks++; if (stall_cnt_o !== exp_cnt) begin errors++; $display("FAIL lu_cnt: got %0d exp %0d", stall_cnt_o, exp_cnt); end
  endtask

  task automatic test_mul();
    reset_and_start();
    mul_issue_i = 1'b1;
    #1;
    checks++; if (obs !== NORM_V) begin errors++; $display("FAIL mul_issue_cycle: got %b exp %b", obs, NORM_V); end
    cyc();
    mul_issue_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      branch_taken_i = (i == 1);
      mul_issue_i = (i == 2);
      ex_memread_i = (i == 0); ex_rtaddr_i = 5'd6; rsaddr_i = 5'd6;
      #1;
      checks++; if (obs !== MWAIT_V) begin errors++; $display("FAIL mul_wait_%0d: got %b exp %b", i, obs, MWAIT_V); end
      exp_stalls++;
      cyc();
      clear_inputs();
    end
    #1;
    checks++; if (obs !== NORM_V) begin errors++; $display("FAIL mul_done: got %b exp %b", obs, NORM_V); end
    checks++; if (stall_cnt_o !== (PERF ? 32'd3 : 32'd0)) begin errors++; $display("FAIL mul_cnt: got %0d exp %0d", stall_cnt_o, PERF ? 3 : 0); end
    cyc();
    #1;
    checks++; if (obs !== NORM_V) begin errors++; $display("FAIL mul_stays_run: got %b exp %b", obs, NORM_V); end
  endtask

  task automatic test_priority();
    ex_memread_i = 1'b1; ex_rtaddr_i = 5'd4; rsaddr_i = 5'd4; branch_taken_i = 1'b1;
    #1;
    checks++; if (obs !== STALL_V) begin errors++; $display("FAIL prio_lu_branch: got %b exp %b", obs, STALL_V); end
    exp_stalls++;
    cyc();
    ex_memread_i = 1'b0;
    #1;
    checks++; if (obs !== FLUSH_V) begin errors++; $display("FAIL prio_branch_retry: got %b exp %b", obs, FLUSH_V); end
    cyc();
    branch_taken_i = 1'b0;
    #1;
    checks++; if (obs !== NORM_V) begin errors++; $display("FAIL flush_one_cycle: got %b exp %b", obs, NORM_V); end
    cyc();
    ex_memread_i = 1'b1; mul_issue_i = 1'b1;
    #1;
    checks++; if (obs !== STALL_V) begin errors++; $display("FAIL prio_lu_mul: got %b exp %b", obs, STALL_V); end
    exp_stalls++;
    cyc();
    ex_memread_i = 1'b0; branch_taken_i = 1'b1;
    #1;
    checks++; if (obs !== NORM_V) begin errors++; $display("FAIL prio_mul_branch: got %b exp %b", obs, NORM_V); end
    cyc();
    clear_inputs();
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (obs !== MWAIT_V) begin errors++; $display("FAIL prio_wait_%0d: got %b exp %b", i, obs, MWAIT_V); end
      exp_stalls++;
      cyc();
    end
    #1;
    checks++; if (obs !== NORM_V) begin errors++; $display("FAIL prio_done: got %b exp %b", obs, NORM_V); end
    checks++; if (stall_cnt_o !== exp_cnt) begin errors++; $display("FAIL prio_cnt: got %0d exp %0d", stall_cnt_o, exp_cnt); end
  endtask

  task automatic test_reset_mid_mul();
    mul_issue_i = 1'b1;
    cyc();
    mul_issue_i = 1'b0;
    cyc();
    #1;
    checks++; if (obs !== MWAIT_V) begin errors++; $display("FAIL midmul_pre: got %b exp %b", obs, MWAIT_V); end
    rst_i = 1'b0;
    exp_stalls = 0;
    #1;
    checks++; if (obs !== IDLE_V) begin errors++; $display("FAIL midmul_reset: got %b exp %b", obs, IDLE_V); end
    checks++; if (stall_cnt_o !== 32'd0) begin errors++; $display("FAIL midmul_cnt: got %0d exp 0", stall_cnt_o); end
    cyc();
    rst_i = 1'b1;
    cyc();
    #1;
    checks++; if (obs !== IDLE_V) begin errors++; $display("FAIL midmul_release: got %b exp %b", obs, IDLE_V); end
    start_i = 1'b1;
    cyc();
    start_i = 1'b0;
    #1;
    checks++; if (obs !== NORM_V) begin errors++; $display("FAIL midmul_restart: got %b exp %b", obs, NORM_V); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_mul();
    test_priority();
    test_reset_mid_mul();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout exp finish");
    $fatal(1, "timeout");
  end

endmodule
